pipeline_mem_arbiter: RTL
=========================

Name: pipeline_mem_arbiter

Overview:
- Arbitrates cacheline requests from the instruction-side cache and the data-side cache onto the single shared physical memory port of the pipelined core.
- Converts each 256-bit line transfer into a 4-beat 64-bit burst on the memory side.
- Sits between the two caches feeding the pipeline_datapath inst/data ports and main memory.
- Round-robin grant on simultaneous requests, so neither pipeline fetch nor MEM stage starves.

Parameters:
LINE_BITS, 256, cacheline width seen by the caches
BEAT_BITS, 64, physical memory data width per beat
ADDR_BITS, 32, address width

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
i_read  in  1  instruction cache line read request
i_addr  in  ADDR_BITS  instruction line address
i_rdata  out  LINE_BITS  line returned to instruction cache
i_resp  out  1  one-cycle completion pulse for instruction request
d_read  in  1  data cache line read request
d_write  in  1  data cache line writeback request
d_addr  in  ADDR_BITS  data line address
d_wdata  in  LINE_BITS  writeback line
d_rdata  out  LINE_BITS  line returned to data cache
d_resp  out  1  one-cycle completion pulse for data request
pmem_read  out  1  memory burst read
pmem_write  out  1  memory burst write
pmem_addr  out  ADDR_BITS  line-aligned burst address
pmem_wdata  out  BEAT_BITS  current write beat
pmem_rdata  in  BEAT_BITS  current read beat
pmem_resp  in  1  beat accepted/valid this cycle

Behaviour:
- BEATS = LINE_BITS/BEAT_BITS (4); beat counter width clog2(BEATS).
- States: IDLE, I_RD, D_RD, D_WR, RESP.
- Reset (async, reset==0): state IDLE, beat count 0, last_grant=INST, line buffer 0, latched addr 0. All outputs 0: pmem_read, pmem_write, i_resp, d_resp, pmem_addr, pmem_wdata, i_rdata, d_rdata. Takes effect immediately, including mid-burst; an interrupted burst is abandoned with no resp.
- IDLE:
  - Only instruction request pending -> I_RD.
  - Only data request pending -> D_RD or D_WR.
  - Both pending -> grant the side not equal to last_grant. First tie after reset goes to data.
  - On grant:
    - latch addr with low log2(LINE_BITS/8) bits cleared;
    - latch d_wdata into the line buffer for writes;
    - update last_grant;
    - clear beat count.
  - d_read and d_write both 1 is illegal; treat as write.
- I_RD/D_RD:
  - pmem_read=1 in every cycle of the state (first asserted the cycle after the grant).
  - Each cycle with pmem_resp=1: line_buf[cnt*BEAT_BITS +: BEAT_BITS] <= pmem_rdata, cnt++.
  - Beat 0 is the lowest bits.
- D_WR:
  - pmem_write=1 throughout the state.
  - pmem_wdata = line_buf[cnt*BEAT_BITS +: BEAT_BITS] (combinational from cnt).
  - cnt++ on each pmem_resp.
- pmem_addr = latched addr in all burst states, 0 otherwise.
- pmem_resp=0 cycles are wait states: hold cnt and strobes.
- Burst end: pmem_resp on beat BEATS-1 -> RESP; cnt wraps to 0.
- RESP: exactly one cycle.
  - pmem_read/write=0.
  - i_resp or d_resp=1 per the granted side; d_resp also for writes.
  - Then IDLE.
- Read data outputs:
  - i_rdata/d_rdata drive line_buf, valid in the RESP cycle.
  - Held stable until the next grant to that side.
- Requester contract: drop the request the cycle after resp. IDLE re-evaluates the next cycle, so back-to-back grants are possible with one IDLE cycle between bursts.
- Requester deasserting mid-burst: burst still completes and resp is still pulsed (no abort).
- Ignored inputs:
  - pmem_resp in IDLE/RESP is ignored.
  - Request inputs and addresses changing during a burst are ignored.
- Zero-wait latency: request sampled in cycle 0, beats in cycles 1-4, resp in cycle 5, next grant evaluated in cycle 6.

Test Plan:
- Instruction read alone: i_read=1, i_addr=0x0000_104C, memory returns beats 0x11..,0x22..,0x33..,0x44.. with no waits -> pmem_read cycles 1-4, pmem_addr=0x0000_1040, i_resp pulse cycle 5, i_rdata={0x44..,0x33..,0x22..,0x11..}, d_resp never asserted.
- Data writeback: d_write=1, d_addr=0x8000_0020, d_wdata=256'h{D,C,B,A} -> pmem_write held 4 beats, pmem_wdata A,B,C,D in order, d_resp single pulse after beat 4.
- Tie after reset: i_read and d_read both 1 in the same cycle -> data served first, instruction burst starts the cycle after IDLE following d_resp; a second simultaneous tie then goes to instruction.
- Wait states: pmem_resp pattern 1,0,0,1,1,0,1 -> cnt advances only on 1s, pmem_read stays high 7 cycles, resp 1 cycle after the 7th.
- Reset mid-burst: assert reset=0 after beat 2 of a read -> pmem_read drops the same cycle (async), no i_resp; after release, a new request restarts at beat 0.
- Requester drops i_read during burst -> burst completes, i_resp still pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/pipeline_mem_arbiter.sv
// pipeline_mem_arbiter
//   Shares one physical memory port between the instruction-side and data-side
//   caches. Each 256-bit cacheline transfer becomes a burst of 64-bit beats.
//   Simultaneous requests are granted round-robin.
//
// Ports
//   clk, reset              clock; asynchronous active-low reset
//   i_read, i_addr          instruction line read request / address
//   i_rdata, i_resp         returned instruction line / one-cycle completion pulse
//   d_read, d_write, d_addr data line read / writeback request / address
//   d_wdata                 writeback line
//   d_rdata, d_resp         returned data line / one-cycle completion pulse
//   pmem_read, pmem_write   memory burst strobes, held for the whole burst
//   pmem_addr               line-aligned burst address (0 outside bursts)
//   pmem_wdata, pmem_rdata  current write beat / current read beat
//   pmem_resp               beat accepted or valid this cycle
module pipeline_mem_arbiter #(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64,
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_read,
    input  logic [ADDR_BITS-1:0] i_addr,
    output logic [LINE_BITS-1:0] i_rdata,
    output logic                 i_resp,
    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic [LINE_BITS-1:0] d_wdata,
    output logic [LINE_BITS-1:0] d_rdata,
    output logic                 d_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    output logic [ADDR_BITS-1:0] pmem_addr,
    output logic [BEAT_BITS-1:0] pmem_wdata,
    input  logic [BEAT_BITS-1:0] pmem_rdata,
    input  logic                 pmem_resp
);

    localparam int unsigned BEATS       = LINE_BITS / BEAT_BITS;
    localparam int unsigned CNT_BITS    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_BITS / 8);

    localparam logic [ADDR_BITS-1:0] ADDR_MASK =
        {{(ADDR_BITS - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIRd,
        StDRd,
        StDWr,
        StResp
    } state_e;

    typedef enum logic {
        GrantInst,
        GrantData
    } side_e;

    state_e               state_q, state_d;
    side_e                last_grant_q, last_grant_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic [LINE_BITS-1:0] line_buf_q, line_buf_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [LINE_BITS-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_BITS-1:0] d_rdata_q, d_rdata_d;

    logic i_req, d_req, grant_data, last_beat, in_rd, in_wr;

    assign i_req      = i_read;
    assign d_req      = d_read | d_write;
    // On a tie the side that was not granted last wins; last_grant resets to
    // instruction so the first tie goes to data.
    assign grant_data = d_req & (~i_req | (last_grant_q == GrantInst));
    assign last_beat  = (cnt_q == LAST_BEAT);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        line_buf_d   = line_buf_q;
        addr_d       = addr_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    cnt_d = '0;
                    if (grant_data) begin
                        last_grant_d = GrantData;
                        addr_d       = d_addr & ADDR_MASK;
                        // read+write together is illegal; it is served as a write
                        if (d_write) begin
                            state_d    = StDWr;
                            line_buf_d = d_wdata;
                        end else begin
                            state_d = StDRd;
                        end
                    end else begin
                        last_grant_d = GrantInst;
                        addr_d       = i_addr & ADDR_MASK;
                        state_d      = StIRd;
                    end
                end
            end
            StIRd, StDRd: begin
                if (pmem_resp) begin
                    line_buf_d[cnt_q*BEAT_BITS +: BEAT_BITS] = pmem_rdata;
                    cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StResp;
                        // Returned lines live in per-side registers so a burst
                        // for the other side cannot disturb them.
                        if (state_q == StIRd) begin
                            i_rdata_d = line_buf_d;
                        end else begin
                            d_rdata_d = line_buf_d;
                        end
                    end
                end
            end
            StDWr: begin
                if (pmem_resp) begin
                    cnt_d = last_beat ? '0 : cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantInst;
            cnt_q        <= '0;
            line_buf_q   <= '0;
            addr_q       <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            line_buf_q   <= line_buf_d;
            addr_q       <= addr_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign in_rd      = (state_q == StIRd) || (state_q == StDRd);
    assign in_wr      = (state_q == StDWr);
    assign pmem_read  = in_rd;
    assign pmem_write = in_wr;
    assign pmem_addr  = (in_rd || in_wr) ? addr_q : '0;
    assign pmem_wdata = in_wr ? line_buf_q[cnt_q*BEAT_BITS +: BEAT_BITS] : '0;
    assign i_resp     = (state_q == StResp) && (last_grant_q == GrantInst);
    assign d_resp     = (state_q == StResp) && (last_grant_q == GrantData);
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;

endmodule
